ahb_output_port: RTL and testbench

//   AHB-Lite slave that writes 32-bit words to an external consumer through a DEPTH-entry FIFO.

---
 rtl/ahb_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/ahb_output_port.sv | 90 +++++++++
 tb/tb_ahb_output_port.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and the status word layout for the M0 bus slaves.
package ahb_pkg;

    localparam logic [1:0] HTRANS_NO_TRANSFER = 2'b00;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    localparam int unsigned STAT_EMPTY     = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_COUNT_LSB = 8;

    // Status word: {16'h0, count[7:0], 6'h0, full, empty}
    function automatic logic [31:0] pack_status(input logic [7:0] count,
                                                 input logic       full,
                                                 input logic       empty);
        logic [31:0] w;
        w                       = '0;
        w[STAT_EMPTY]           = empty;
        w[STAT_FULL]            = full;
        w[STAT_COUNT_LSB +: 8]  = count;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; head word presented on rdata (zero when empty), no fall-through.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    // A slot freed by a same-cycle pop may be refilled immediately.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; reads are masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ahb_output_port.sv
// AHB-Lite slave pushing written words into a FIFO drained by a valid/ready consumer.
module ahb_output_port
    import ahb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic        HSEL,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [31:0] oData,
    output logic        oValid,
    input  logic        oReady
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          write_en_q, write_en_d;
    logic          rd_en_q, rd_en_d;
    logic          sel_q, sel_d;
    logic          push, pop, data_wr;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          unused_c;

    assign unused_c = ^{HSIZE, HADDR[31:3], HADDR[1:0]};

    // Address-phase capture; held across wait states.
    always_comb begin
        write_en_d = write_en_q;
        rd_en_d    = rd_en_q;
        sel_d      = sel_q;
        if (HREADY) begin
            if (HSEL && (HTRANS != HTRANS_NO_TRANSFER)) begin
                write_en_d = HWRITE;
                rd_en_d    = !HWRITE;
                sel_d      = HADDR[2];
            end else begin
                write_en_d = 1'b0;
                rd_en_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            write_en_q <= 1'b0;
            rd_en_q    <= 1'b0;
            sel_q      <= 1'b0;
        end else begin
            write_en_q <= write_en_d;
            rd_en_q    <= rd_en_d;
            sel_q      <= sel_d;
        end
    end

    assign pop       = oValid && oReady;
    assign data_wr   = write_en_q && (sel_q == ADDR_DATA);
    assign push      = data_wr && (!fifo_full || pop);
    assign HREADYOUT = !(data_wr && fifo_full && !pop);
    assign oValid    = !fifo_empty;

    // Status reflects the count before any same-cycle push/pop.
    assign HRDATA = (rd_en_q && (sel_q == ADDR_STATUS))
                  ? pack_status(8'(fifo_count), fifo_full, fifo_empty)
                  : 32'h0;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (push),
        .pop   (pop),
        .wdata (HWDATA),
        .rdata (oData),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_ahb_output_port.sv
// Directed self-checking bench for ahb_output_port (DEPTH = 4).
module tb_ahb_output_port;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY;
    logic        HSEL;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [31:0] oData;
    logic        oValid;
    logic        oReady;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned stall_cnt = 0;
    logic        mon_en = 1'b0;
    logic [31:0] got_q[$];
    logic [31:0] rd;

    // Single slave on the bus: its HREADYOUT is the bus HREADY.
    assign HREADY = HREADYOUT;

    ahb_output_port #(.DEPTH(4)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HSIZE     (HSIZE),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HREADY    (HREADY),
        .HSEL      (HSEL),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .oData     (oData),
        .oValid    (oValid),
        .oReady    (oReady)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    always @(negedge HCLK) begin
        if (mon_en) begin
            if (oValid && oReady) got_q.push_back(oData);
            if (!HREADYOUT) stall_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = 32'h0;
    endtask

    // Address phase then data phase; returns in the data phase (possibly stalled).
    task automatic write_start(input logic sel, input logic [1:0] trans,
                               input logic [31:0] addr, input logic [31:0] data);
        @(posedge HCLK); #1;
        HSEL = sel; HTRANS = trans; HWRITE = 1'b1; HADDR = addr;
        @(posedge HCLK); #1;
        bus_idle();
        HWDATA = data;
    endtask

    task automatic write_finish();
        int unsigned n;
        n = 0;
        while (!HREADYOUT && n < 1000) begin
            @(posedge HCLK); #1;
            n++;
        end
        if (!HREADYOUT) check("write_timeout", 32'(HREADYOUT), 32'h1);
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        write_start(1'b1, 2'b10, addr, data);
        write_finish();
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        @(posedge HCLK); #1;
        bus_idle();
        data = HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        check({tag, "_valid"}, 32'(oValid), 32'h1);
        check({tag, "_data"}, oData, exp);
        oReady = 1'b1;
        @(posedge HCLK); #1;
        oReady = 1'b0;
    endtask

    initial begin
        HRESETn = 1'b0;
        HSIZE   = 3'b010;
        HWDATA  = 32'h0;
        oReady  = 1'b0;
        bus_idle();
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        // 1: reset state
        check("rst_hreadyout", 32'(HREADYOUT), 32'h1);
        check("rst_ovalid", 32'(oValid), 32'h0);
        check("rst_odata", oData, 32'h0);
        ahb_read(32'h4, rd);
        check("rst_status", rd, 32'h0000_0001);

        // 2: single write, then one consumer pop
        ahb_write(32'h0, 32'hDEAD_BEEF);
        check("single_ovalid", 32'(oValid), 32'h1);
        check("single_odata", oData, 32'hDEAD_BEEF);
        ahb_read(32'h4, rd);
        check("single_status", rd, 32'h0000_0100);
        oReady = 1'b1;
        @(posedge HCLK); #1;
        oReady = 1'b0;
        check("single_drained", 32'(oValid), 32'h0);

        // 3: fill, stall on the fifth write, release with one pop
        for (int i = 1; i <= 4; i++) ahb_write(32'h0, 32'(i));
        ahb_read(32'h4, rd);
        check("full_status", rd, 32'h0000_0402);
        write_start(1'b1, 2'b10, 32'h0, 32'h5);
        check("stall_head", oData, 32'h1);
        for (int i = 0; i < 10; i++) begin
            check("stall_hreadyout", 32'(HREADYOUT), 32'h0);
            @(posedge HCLK); #1;
        end
        oReady = 1'b1;
        #1;
        check("stall_release", 32'(HREADYOUT), 32'h1);
        write_finish();
        oReady = 1'b0;
        for (int i = 2; i <= 5; i++) pop_check("order", 32'(i));
        ahb_read(32'h4, rd);
        check("drain_status", rd, 32'h0000_0001);

        // 4: wrap-around with an always-ready consumer
        oReady = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) ahb_write(32'h0, 32'hA000_0000 + 32'(i));
        repeat (2) @(posedge HCLK);
        #1 mon_en = 1'b0;
        oReady = 1'b0;
        check("wrap_count", 32'(got_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < got_q.size()) check("wrap_word", got_q[i], 32'hA000_0000 + 32'(i));
        end
        check("wrap_stalls", 32'(stall_cnt), 32'h0);
        ahb_read(32'h4, rd);
        check("wrap_status", rd, 32'h0000_0001);

        // 5: status writes, unselected and IDLE transfers never push
        ahb_write(32'h0, 32'h0000_0077);
        ahb_write(32'h4, 32'h0000_0099);
        write_start(1'b0, 2'b10, 32'h0, 32'h0000_00AA);
        write_finish();
        write_start(1'b1, 2'b00, 32'h0, 32'h0000_00BB);
        write_finish();
        ahb_read(32'h4, rd);
        check("nopush_status", rd, 32'h0000_0100);
        ahb_read(32'h0, rd);
        check("data_read_zero", rd, 32'h0);
        pop_check("nopush_head", 32'h0000_0077);

        // 6: asynchronous reset in the middle of a stall
        for (int i = 0; i < 4; i++) ahb_write(32'h0, 32'hC0 + 32'(i));
        write_start(1'b1, 2'b10, 32'h0, 32'hC4);
        check("pre_rst_stall", 32'(HREADYOUT), 32'h0);
        #2 HRESETn = 1'b0;
        #1;
        check("mid_rst_hreadyout", 32'(HREADYOUT), 32'h1);
        check("mid_rst_ovalid", 32'(oValid), 32'h0);
        check("mid_rst_odata", oData, 32'h0);
        check("mid_rst_hrdata", HRDATA, 32'h0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        ahb_read(32'h4, rd);
        check("post_rst_status", rd, 32'h0000_0001);
        check("post_rst_ovalid", 32'(oValid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
